// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Sequencer and two-port arbiter for the shared single-port memory. Fetch
// (read-only) and data (load/store) requests are serialised onto the memory
// pins. The pins are held for WAIT_CYCLES clocks per access, and each access is
// followed by one DONE cycle that pulses the owner's ack and leaves the bus
// idle for one turnaround cycle.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   -> when both ports request in the same
//                                        cycle, the port not granted last wins
//                           undefined -> fixed priority, data port wins
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   if_req/if_addr              fetch request and address
//   if_ack/if_rdata             fetch done pulse and fetched word
//   dp_req/dp_we/dp_addr/
//   dp_wdata                    data-port request (we=1 store), addr, data
//   dp_ack/dp_rdata             data-port done pulse and loaded word
//   mem_addr/mem_load/
//   mem_store/mem_data          memory pins; mem_data driven only on stores
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic              dp_ack,
    output logic [DATA_W-1:0] dp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_load,
    output logic              mem_store,
    inout  wire  [DATA_W-1:0] mem_data
);

    // WAIT_CYCLES is at most 15, so four bits hold WAIT_CYCLES-1.
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              owner_dp;   // 1: current access belongs to the data port
    logic              we_q;       // 1: current access is a store
    logic              drive_en;   // store data on mem_data
    logic [DATA_W-1:0] wdata_q;
    logic              grant_dp_c; // arbitration result for this cycle
    logic              grant_st_c; // granted access is a store

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_was_dp;             // owner of the most recent grant

    // Contended cycle: the port not served last wins.
    always_comb begin
        grant_dp_c = dp_req;
        if (dp_req && if_req) begin
            grant_dp_c = ~last_was_dp;
        end
    end

    // Pointer follows every grant; reset value lets the data port win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_was_dp <= 1'b0;
        end else if (state == S_IDLE && (if_req || dp_req)) begin
            last_was_dp <= grant_dp_c;
        end
    end
`else
    // Fixed priority: any data request beats a fetch.
    always_comb begin
        grant_dp_c = dp_req;
    end
`endif

    always_comb begin
        grant_st_c = grant_dp_c & dp_we;
    end

    // Only this block ever drives the shared data pins.
    assign mem_data = drive_en ? wdata_q : {DATA_W{1'bz}};

    // Access sequencer: IDLE -> ACCESS (WAIT_CYCLES clocks) -> DONE -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            owner_dp  <= 1'b0;
            we_q      <= 1'b0;
            drive_en  <= 1'b0;
            wdata_q   <= '0;
            mem_addr  <= '0;
            mem_load  <= 1'b0;
            mem_store <= 1'b0;
            if_ack    <= 1'b0;
            dp_ack    <= 1'b0;
            if_rdata  <= '0;
            dp_rdata  <= '0;
        end else begin
            if_ack    <= 1'b0;
            dp_ack    <= 1'b0;
            mem_store <= 1'b0;   // store strobe lasts one ACCESS cycle only
            case (state)
                S_IDLE: begin
                    if (if_req || dp_req) begin
                        owner_dp  <= grant_dp_c;
                        we_q      <= grant_st_c;
                        mem_addr  <= grant_dp_c ? dp_addr : if_addr;
                        wdata_q   <= dp_wdata;
                        cnt       <= CNT_W'(WAIT_CYCLES - 1);
                        mem_load  <= ~grant_st_c;
                        mem_store <= grant_st_c;
                        drive_en  <= grant_st_c;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (cnt == '0) begin
                        // Last ACCESS edge: capture load data, release pins.
                        if (!we_q) begin
                            if (owner_dp) begin
                                dp_rdata <= mem_data;
                            end else begin
                                if_rdata <= mem_data;
                            end
                        end
                        mem_load <= 1'b0;
                        drive_en <= 1'b0;
                        dp_ack   <= owner_dp;
                        if_ack   <= ~owner_dp;
                        state    <= S_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A behavioural memory sits on the pins;
// a separate reference memory predicts load results at transaction level.
// Compile with MEM_ARB_ROUND_ROBIN_EN to check round-robin arbitration.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int unsigned W      = 3;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              dp_req;
    logic              dp_we;
    logic [ADDR_W-1:0] dp_addr;
    logic [DATA_W-1:0] dp_wdata;
    logic              dp_ack;
    logic [DATA_W-1:0] dp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_load;
    logic              mem_store;
    wire  [DATA_W-1:0] mem_data;

    int checks = 0;
    int errors = 0;
    int mon_checks = 0;
    int mon_bad = 0;
    int mon_first_bad = -1;
    int mon_cycle = 0;

    logic [DATA_W-1:0] phys [0:65535];
    logic [DATA_W-1:0] ref_mem [int];
    logic [DATA_W-1:0] exp_if_rdata;
    logic [DATA_W-1:0] exp_dp_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
        .dp_ack(dp_ack), .dp_rdata(dp_rdata),
        .mem_addr(mem_addr), .mem_load(mem_load), .mem_store(mem_store),
        .mem_data(mem_data)
    );

    // Memory drives the data pins while load is asserted.
    assign mem_data = mem_load ? phys[mem_addr] : 16'hzzzz;

    function automatic logic [15:0] init_val(input logic [15:0] a);
        if (a == 16'h0003) return 16'h7002;
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    // Behavioural memory plus bus-rule monitor (sole writer of phys).
    initial begin
        for (int i = 0; i < 65536; i++) phys[i] = init_val(16'(i));
        forever begin
            @(negedge clk);
            mon_cycle++;
            if (mem_store) phys[mem_addr] = mem_data;
            if (mem_load || mem_store) begin
                mon_checks++;
                if (mem_load && mem_store) begin
                    mon_bad++;
                    if (mon_first_bad < 0) mon_first_bad = mon_cycle;
                end
            end
            if (mem_load) begin
                mon_checks++;
                if (mem_data !== phys[mem_addr]) begin
                    mon_bad++;
                    if (mon_first_bad < 0) mon_first_bad = mon_cycle;
                end
            end
            if (if_ack || dp_ack) begin
                mon_checks++;
                if (if_ack && dp_ack) begin
                    mon_bad++;
                    if (mon_first_bad < 0) mon_first_bad = mon_cycle;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        if_req = 1'b0;
        dp_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_if_rdata = '0;
        exp_dp_rdata = '0;
    endtask

    // One access from an idle arbiter; cycle 1 is the cycle req is raised.
    task automatic run_access(input bit is_dp, input bit we, input logic [15:0] addr,
                              input logic [15:0] wdata, output int lat, output int nload,
                              output int nstore, output int n_if, output int n_dp,
                              output bit tmo);
        int cyc;
        bit seen;
        lat = 0; nload = 0; nstore = 0; n_if = 0; n_dp = 0; tmo = 1'b1; seen = 1'b0;
        @(negedge clk);
        if (is_dp) begin
            dp_req = 1'b1; dp_we = we; dp_addr = addr; dp_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr; dp_wdata = 16'($urandom);
        end
        cyc = 1;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                dp_req = 1'b0;
                if_req = 1'b0;
            end
            if (mem_load) nload++;
            if (mem_store) nstore++;
            if (if_ack) n_if++;
            if (dp_ack) n_dp++;
            if (seen) begin
                tmo = 1'b0;
                break;
            end
            if (if_ack || dp_ack) begin
                lat = cyc;
                seen = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dp_req = 1'b0; dp_we = 1'b0; dp_addr = '0; dp_wdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (mem_load !== 1'b0) begin errors++; $display("FAIL reset_mem_load got %b want 0", mem_load); end
        checks++; if (mem_store !== 1'b0) begin errors++; $display("FAIL reset_mem_store got %b want 0", mem_store); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (if_ack !== 1'b0 || dp_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got if=%b dp=%b want 0 0", if_ack, dp_ack); end
        checks++; if (if_rdata !== 16'h0) begin errors++; $display("FAIL reset_if_rdata got %h want 0000", if_rdata); end
        checks++; if (dp_rdata !== 16'h0) begin errors++; $display("FAIL reset_dp_rdata got %h want 0000", dp_rdata); end
        checks++; if (mem_load !== 1'b0) begin errors++; $display("FAIL idle_mem_load got %b want 0", mem_load); end
        exp_if_rdata = '0;
        exp_dp_rdata = '0;
    endtask

    task automatic test_fetch_read();
        int lat, nl, ns, ni, nd;
        bit tmo;
        run_access(1'b0, 1'b0, 16'h0003, 16'h0, lat, nl, ns, ni, nd, tmo);
        exp_if_rdata = 16'h7002;
        checks++; if (tmo) begin errors++; $display("FAIL fetch_timeout got no ack want ack"); end
        checks++; if (lat != int'(W) + 2) begin errors++; $display("FAIL fetch_latency got %0d want %0d", lat, W + 2); end
        checks++; if (nl != int'(W)) begin errors++; $display("FAIL fetch_load_cycles got %0d want %0d", nl, W); end
        checks++; if (ns != 0) begin errors++; $display("FAIL fetch_store_cycles got %0d want 0", ns); end
        checks++; if (ni != 1 || nd != 0) begin errors++; $display("FAIL fetch_acks got if=%0d dp=%0d want 1 0", ni, nd); end
        checks++; if (if_rdata !== exp_if_rdata) begin errors++; $display("FAIL fetch_rdata got %h want %h", if_rdata, exp_if_rdata); end
        checks++; if (dp_rdata !== exp_dp_rdata) begin errors++; $display("FAIL fetch_dp_rdata got %h want %h", dp_rdata, exp_dp_rdata); end
    endtask

    task automatic test_store_load();
        int lat, nl, ns, ni, nd;
        bit tmo;
        run_access(1'b1, 1'b1, 16'h0100, 16'hBEEF, lat, nl, ns, ni, nd, tmo);
        ref_mem[32'h100] = 16'hBEEF;
        checks++; if (tmo) begin errors++; $display("FAIL store_timeout got no ack want ack"); end
        checks++; if (lat != int'(W) + 2) begin errors++; $display("FAIL store_latency got %0d want %0d", lat, W + 2); end
        checks++; if (ns != 1 || nl != 0) begin errors++; $display("FAIL store_strobes got store=%0d load=%0d want 1 0", ns, nl); end
        checks++; if (nd != 1 || ni != 0) begin errors++; $display("FAIL store_acks got if=%0d dp=%0d want 0 1", ni, nd); end
        checks++; if (dp_rdata !== exp_dp_rdata) begin errors++; $display("FAIL store_keeps_rdata got %h want %h", dp_rdata, exp_dp_rdata); end
        run_access(1'b1, 1'b0, 16'h0100, 16'h1234, lat, nl, ns, ni, nd, tmo);
        exp_dp_rdata = 16'hBEEF;
        checks++; if (tmo) begin errors++; $display("FAIL load_timeout got no ack want ack"); end
        checks++; if (nl != int'(W) || ns != 0) begin errors++; $display("FAIL load_strobes got load=%0d store=%0d want %0d 0", nl, ns, W); end
        checks++; if (nd != 1 || ni != 0) begin errors++; $display("FAIL load_acks got if=%0d dp=%0d want 0 1", ni, nd); end
        checks++; if (dp_rdata !== exp_dp_rdata) begin errors++; $display("FAIL load_rdata got %h want %h", dp_rdata, exp_dp_rdata); end
        checks++; if (if_rdata !== exp_if_rdata) begin errors++; $display("FAIL load_if_rdata got %h want %h", if_rdata, exp_if_rdata); end
    endtask

    // Both ports request together; expected grant order depends on the build.
    task automatic test_arbitration();
        int order[$];
        int stamps[$];
        int exp_order[$];
        int cyc, dp_seen;
        bit done;
        do_reset();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order.push_back(1); exp_order.push_back(0);
        exp_order.push_back(1); exp_order.push_back(0);
`else
        exp_order.push_back(1); exp_order.push_back(1); exp_order.push_back(0);
`endif
        @(negedge clk);
        dp_req = 1'b1; dp_we = 1'b0; dp_addr = 16'h0101; dp_wdata = 16'($urandom);
        if_req = 1'b1; if_addr = 16'h0002;
        cyc = 1; dp_seen = 0; done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (dp_ack) begin
                order.push_back(1); stamps.push_back(cyc); dp_seen++;
`ifndef MEM_ARB_ROUND_ROBIN_EN
                if (dp_seen == 2) dp_req = 1'b0;
`endif
            end
            if (if_ack) begin
                order.push_back(0); stamps.push_back(cyc);
`ifndef MEM_ARB_ROUND_ROBIN_EN
                if_req = 1'b0; done = 1'b1;
`endif
            end
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (order.size() >= 4) begin
                dp_req = 1'b0; if_req = 1'b0; done = 1'b1;
            end
`endif
        end
        dp_req = 1'b0; if_req = 1'b0;
        @(negedge clk);
        exp_dp_rdata = ref_read(16'h0101);
        exp_if_rdata = ref_read(16'h0002);
        checks++; if (!done) begin errors++; $display("FAIL arb_timeout got %0d acks want %0d", order.size(), exp_order.size()); end
        checks++; if (order.size() != exp_order.size()) begin errors++; $display("FAIL arb_count got %0d want %0d", order.size(), exp_order.size()); end
        for (int i = 0; i < exp_order.size() && i < order.size(); i++) begin
            checks++; if (order[i] != exp_order[i]) begin errors++; $display("FAIL arb_order[%0d] got %s want %s", i, order[i] ? "dp" : "if", exp_order[i] ? "dp" : "if"); end
        end
        if (stamps.size() > 0) begin
            checks++; if (stamps[0] != int'(W) + 2) begin errors++; $display("FAIL arb_first_ack got %0d want %0d", stamps[0], W + 2); end
        end
        for (int i = 1; i < stamps.size(); i++) begin
            checks++; if (stamps[i] - stamps[i-1] != int'(W) + 2) begin errors++; $display("FAIL arb_spacing[%0d] got %0d want %0d", i, stamps[i] - stamps[i-1], W + 2); end
        end
        checks++; if (dp_rdata !== exp_dp_rdata) begin errors++; $display("FAIL arb_dp_rdata got %h want %h", dp_rdata, exp_dp_rdata); end
        checks++; if (if_rdata !== exp_if_rdata) begin errors++; $display("FAIL arb_if_rdata got %h want %h", if_rdata, exp_if_rdata); end
    endtask

    task automatic test_reset_mid_access();
        int nack, lat, nl, ns, ni, nd;
        bit tmo;
        nack = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0005;
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_load !== 1'b1) begin errors++; $display("FAIL rstmid_pre_load got %b want 1", mem_load); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_load !== 1'b0 || mem_store !== 1'b0) begin errors++; $display("FAIL rstmid_strobes got load=%b store=%b want 0 0", mem_load, mem_store); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rstmid_addr got %h want 0000", mem_addr); end
        checks++; if (if_rdata !== 16'h0) begin errors++; $display("FAIL rstmid_if_rdata got %h want 0000", if_rdata); end
        exp_if_rdata = '0;
        exp_dp_rdata = '0;
        repeat (2) begin
            @(negedge clk);
            if (if_ack || dp_ack) nack++;
        end
        rst_n = 1'b1;
        repeat (W + 3) begin
            @(negedge clk);
            if (if_ack || dp_ack) nack++;
        end
        checks++; if (nack != 0) begin errors++; $display("FAIL rstmid_no_ack got %0d acks want 0", nack); end
        run_access(1'b1, 1'b0, 16'h0100, 16'h0, lat, nl, ns, ni, nd, tmo);
        exp_dp_rdata = ref_read(16'h0100);
        checks++; if (tmo || lat != int'(W) + 2) begin errors++; $display("FAIL rstmid_recover_latency got %0d want %0d", lat, W + 2); end
        checks++; if (dp_rdata !== exp_dp_rdata) begin errors++; $display("FAIL rstmid_recover_rdata got %h want %h", dp_rdata, exp_dp_rdata); end
    endtask

    task automatic test_random();
        int kind, lat, nl, ns, ni, nd;
        bit tmo;
        logic [15:0] addr, wdata;
        for (int n = 0; n < 40; n++) begin
            kind  = int'($urandom_range(0, 2));
            addr  = 16'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 16'h0100 : 16'h0000);
            wdata = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_access(kind != 0, kind == 2, addr, wdata, lat, nl, ns, ni, nd, tmo);
            if (kind == 0) exp_if_rdata = ref_read(addr);
            else if (kind == 1) exp_dp_rdata = ref_read(addr);
            else ref_mem[int'(addr)] = wdata;
            checks++; if (tmo || lat != int'(W) + 2) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", n, lat, W + 2); end
            checks++; if (nl != ((kind == 2) ? 0 : int'(W)) || ns != ((kind == 2) ? 1 : 0)) begin errors++; $display("FAIL rnd%0d_strobes got load=%0d store=%0d kind=%0d", n, nl, ns, kind); end
            checks++; if (ni != ((kind == 0) ? 1 : 0) || nd != ((kind == 0) ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_acks got if=%0d dp=%0d kind=%0d", n, ni, nd, kind); end
            checks++; if (if_rdata !== exp_if_rdata) begin errors++; $display("FAIL rnd%0d_if_rdata got %h want %h", n, if_rdata, exp_if_rdata); end
            checks++; if (dp_rdata !== exp_dp_rdata) begin errors++; $display("FAIL rnd%0d_dp_rdata got %h want %h", n, dp_rdata, exp_dp_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_read();
        test_store_load();
        test_arbitration();
        test_reset_mid_access();
        test_random();
        repeat (2) @(negedge clk);
        checks++;
        if (mon_bad != 0) begin
            errors++;
            $display("FAIL bus_rules got %0d violations (first at cycle %0d) in %0d samples want 0", mon_bad, mon_first_bad, mon_checks);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer and two-port arbiter for the shared single-port 16-bit memory. Takes read requests from the instruction-fetch port and load/store requests from the data port, serialises them onto the memory's `addr`/`load`/`store`/`data` pins, and holds each access for a fixed wait count that covers the memory's access time. Sits between the CPU core and the memory in the top level.

## Interface

Parameters:
- `WAIT_CYCLES`, 3: clock cycles the memory pins are held per access; must cover 54 ns memory time at the system clock; legal range 1..15.
- `ADDR_W`, 16: address width.
- `DATA_W`, 16: data width.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch port read request.
- `if_addr` in ADDR_W: fetch address.
- `if_ack` out 1: one-cycle pulse; `if_rdata` valid.
- `if_rdata` out DATA_W: fetched word.
- `dp_req` in 1: data port request.
- `dp_we` in 1: 1 = store, 0 = load.
- `dp_addr` in ADDR_W: data address.
- `dp_wdata` in DATA_W: store data.
- `dp_ack` out 1: one-cycle pulse; access complete, `dp_rdata` valid for loads.
- `dp_rdata` out DATA_W: loaded word.
- `mem_addr` out ADDR_W: to memory `addr`.
- `mem_load` out 1: to memory `load`.
- `mem_store` out 1: to memory `store`.
- `mem_data` inout DATA_W: to memory `data`; driven only during a store, else `z`.

## Operation

- FSM states: IDLE, ACCESS, DONE.
- IDLE: if any `*_req` is high at a rising edge, grant one requester. Latch grant owner, address, `dp_we`, and `dp_wdata` into internal registers, load the wait counter with `WAIT_CYCLES-1`, and go to ACCESS. If no request is high, stay in IDLE.
- Default arbitration is fixed priority: data port wins when both requests are high.
- ACCESS:
  - `mem_addr` = latched address for the whole state.
  - Load: `mem_load`=1 for the whole state.
  - Store: `mem_store`=1 for the first ACCESS cycle only, so the memory sees exactly one store edge. `mem_data` is driven with the latched wdata for the whole state.
  - The counter decrements each cycle. At count 0, the load data on `mem_data` is captured into the owner's rdata register and the FSM goes to DONE.
- DONE:
  - Owner's `*_ack`=1 for exactly this cycle.
  - `mem_load`=`mem_store`=0, `mem_data`=`z`.
  - Next state is IDLE unconditionally. This gives one turnaround cycle on the bus.
- Requests are level signals. A requester that holds `req` high after its ack gets a new access, arbitrated fresh in IDLE. Address and data only need to be stable at the granting edge.
- `dp_rdata`/`if_rdata` keep their last captured value. A store does not alter `dp_rdata`.
- Reset outputs: `if_ack`=`dp_ack`=0, `mem_load`=`mem_store`=0, `mem_addr`=0, `mem_data`=`z`, `if_rdata`=`dp_rdata`=0, state IDLE, round-robin pointer favours the data port.
- Reset mid-ACCESS: all pins return to their reset values immediately and no ack is issued. A store already edged into the memory may still complete; the requester must reissue it.

## Timing

- Grant edge E (IDLE→ACCESS). ACCESS spans cycles E+1..E+WAIT_CYCLES. The data capture edge is E+WAIT_CYCLES, and ack is high in cycle E+WAIT_CYCLES+1.
- Request-to-ack latency is WAIT_CYCLES+2 cycles from the first sampled request, measured from an idle arbiter.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- `mem_load`/`mem_store` never overlap. `mem_data` is never driven while `mem_load`=1.
- The two ack outputs are never high in the same cycle.

## Configuration

- `MEM_ARB_ROUND_ROBIN_EN` defined: when both requests are high in IDLE, the port not granted last wins. The pointer updates at every grant.
- Undefined: fixed data-port priority; the fetch port can starve under continuous data traffic.

## Test plan

- Fetch read, `if_addr`=0x0003 with memory preloaded 0x7002, WAIT_CYCLES=3 -> `mem_load` high for 3 cycles; `if_ack` pulses in the 5th cycle after the request with `if_rdata`=0x7002.
- Data store to 0x0100 with wdata 0xBEEF, then data load from 0x0100 -> single-cycle `mem_store` pulse, `dp_ack` after each access, `dp_rdata`=0xBEEF, `if_ack` never asserted.
- Both requests raised in the same cycle, macro undefined -> data port served first; fetch is served only after `dp_req` drops.
- Both requests held high, `MEM_ARB_ROUND_ROBIN_EN` defined -> grants alternate dp, if, dp, if; each ack is WAIT_CYCLES+2 cycles apart.
- `rst_n` pulled low in the second ACCESS cycle of a load -> `mem_load`=0 and `mem_data`=`z` immediately; no ack; after release, a new request completes normally.
- Bus check across all scenarios -> `mem_load`&`mem_store` never both 1, and `mem_data` never driven while `mem_load`=1.
